// File: rtl/pwm_audio_dac_pkg.sv
// pwm_audio_dac_pkg: shared synth constants and sample-format helpers
package pwm_audio_dac_pkg;
    localparam int SAMPLE_WIDTH = 8;

    function automatic logic [31:0] mid_scale(input int w);
        return 32'd1 << (w - 1);
    endfunction

    // Two's-complement to offset-binary is just an MSB flip
    function automatic logic [31:0] to_offset_binary(input logic [31:0] s, input int w);
        return s ^ mid_scale(w);
    endfunction

    localparam logic [SAMPLE_WIDTH-1:0] MID_SCALE = SAMPLE_WIDTH'(mid_scale(SAMPLE_WIDTH));
endpackage

// File: rtl/pwm_audio_dac_if.sv
// pwm_audio_dac_if: valid/ready sample stream into the DAC
interface pwm_audio_dac_if import pwm_audio_dac_pkg::*; #(parameter int WIDTH = SAMPLE_WIDTH);
    logic [WIDTH-1:0] sample_in;
    logic sample_valid;
    logic sample_ready;
    modport master(output sample_in, sample_valid, input sample_ready);
    modport slave(input sample_in, sample_valid, output sample_ready);
endinterface

// File: rtl/pwm_audio_dac_tick_counter.sv
// pwm_tick_counter: clock prescaler plus WIDTH-bit PWM period counter
module pwm_tick_counter #(
    parameter int WIDTH = 8,
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    output logic [WIDTH-1:0] cnt,
    output logic tick,
    output logic boundary
);
    localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
    logic [PW-1:0] prescale;
    assign tick = prescale == PW'(DIV - 1);
    assign boundary = tick && cnt == '1;
    always_ff @(posedge clk) begin
        if (rst) begin
            prescale <= '0;
            cnt <= '0;
        end else begin
            prescale <= tick ? '0 : prescale + 1'b1;
            if (tick) cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/pwm_audio_dac.sv
// pwm_audio_dac: signed sample stream to single-bit PWM, one sample per period
module pwm_audio_dac import pwm_audio_dac_pkg::*; #(
    parameter int WIDTH = SAMPLE_WIDTH,
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    pwm_audio_dac_if.slave s,
    output logic sample_req,
    output logic underrun,
    input  logic underrun_clr,
    output logic pwm_out
);
    logic [WIDTH-1:0] cnt, duty, pending, u;
    logic pending_valid, boundary, accept;
    pwm_tick_counter #(.WIDTH(WIDTH), .DIV(DIV)) counter (
        .clk(clk),
        .rst(rst),
        .cnt(cnt),
        .tick(),
        .boundary(boundary)
    );
    assign u = WIDTH'(to_offset_binary(32'(s.sample_in), WIDTH));
    assign s.sample_ready = !pending_valid;
    assign accept = s.sample_valid && !pending_valid;
    // accept and a loading boundary are exclusive, since accept needs pending empty
    always_ff @(posedge clk) begin
        if (rst) begin
            duty <= WIDTH'(mid_scale(WIDTH));
            pending <= '0;
            pending_valid <= 1'b0;
            pwm_out <= 1'b0;
            sample_req <= 1'b0;
            underrun <= 1'b0;
        end else begin
            pwm_out <= cnt < duty;
            sample_req <= boundary;
            if (boundary && pending_valid) duty <= pending;
            if (accept) pending <= u;
            pending_valid <= accept || (pending_valid && !boundary);
            underrun <= (boundary && !pending_valid) || (underrun && !underrun_clr);
        end
    end
endmodule

// File: tb/tb_pwm_audio_dac.sv
// tb_pwm_audio_dac: directed checks for DIV=1 and DIV=4 instances
module tb_pwm_audio_dac;
    logic clk = 1'b0;
    logic rst1, rst4, clr1, clr4;
    logic req1, req4, und1, und4, pwm1, pwm4;
    int checks = 0;
    int errors = 0;
    int n, h, early;
    pwm_audio_dac_if #(.WIDTH(8)) s1();
    pwm_audio_dac_if #(.WIDTH(8)) s4();
    always #5 clk = ~clk;

    pwm_audio_dac #(.WIDTH(8), .DIV(1)) d1 (
        .clk(clk), .rst(rst1), .s(s1), .sample_req(req1),
        .underrun(und1), .underrun_clr(clr1), .pwm_out(pwm1)
    );
    pwm_audio_dac #(.WIDTH(8), .DIV(4)) d4 (
        .clk(clk), .rst(rst4), .s(s4), .sample_req(req4),
        .underrun(und4), .underrun_clr(clr4), .pwm_out(pwm4)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_req(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!req1 && cyc < 3000);
        if (!req1) check("req_timeout", 0, 1);
    endtask

    // Called on a sample_req cycle: sums pwm over the period that duty drives
    task automatic period_high(output int hi);
        hi = 0;
        repeat (256) begin
            @(negedge clk);
            hi += int'(pwm1);
        end
    endtask

    task automatic push(input logic [7:0] v);
        s1.sample_in = v;
        s1.sample_valid = 1'b1;
        @(negedge clk);
        s1.sample_valid = 1'b0;
    endtask

    task automatic pulse_clr();
        clr1 = 1'b1;
        @(negedge clk);
        clr1 = 1'b0;
    endtask

    initial begin
        rst1 = 1'b1; rst4 = 1'b1; clr1 = 1'b0; clr4 = 1'b0;
        s1.sample_in = '0; s1.sample_valid = 1'b0;
        s4.sample_in = '0; s4.sample_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pwm", pwm1, 0);
        check("rst_req", req1, 0);
        check("rst_underrun", und1, 0);
        check("rst_ready", s1.sample_ready, 1);
        rst1 = 1'b0;
        // 1: idle output at mid-scale, underrun after first boundary
        wait_req(n);
        check("t1_first_req", n, 256);
        check("t1_underrun", und1, 1);
        period_high(h);
        check("t1_mid_high", h, 128);
        check("t1_req_spacing", req1, 1);
        check("t1_ready", s1.sample_ready, 1);
        // 2: full-scale extremes and zero
        push(8'h80);
        wait_req(n);
        period_high(h);
        check("t2_neg_full", h, 0);
        push(8'h7f);
        wait_req(n);
        period_high(h);
        check("t2_pos_full", h, 255);
        push(8'h00);
        wait_req(n);
        period_high(h);
        check("t2_zero", h, 128);
        // 3: steady feed, then a withheld sample
        pulse_clr();
        check("t3_clr", und1, 0);
        for (int i = 0; i < 10; i++) begin
            push(8'(i * 8));
            wait_req(n);
        end
        check("t3_no_underrun", und1, 0);
        period_high(h);
        check("t3_last_duty", h, 200);
        check("t3_underrun_set", und1, 1);
        period_high(h);
        check("t3_duty_held", h, 200);
        pulse_clr();
        check("t3_clr_again", und1, 0);
        // 4: back-to-back samples, second waits for the boundary
        wait_req(n);
        s1.sample_in = 8'd10;
        s1.sample_valid = 1'b1;
        @(negedge clk);
        check("t4_ready_low", s1.sample_ready, 0);
        s1.sample_in = 8'd20;
        n = 0;
        early = 0;
        while (!req1 && n < 3000) begin
            if (s1.sample_ready) early++;
            @(negedge clk);
            n++;
        end
        check("t4_ready_held_low", early, 0);
        check("t4_ready_after_boundary", s1.sample_ready, 1);
        @(negedge clk);
        s1.sample_valid = 1'b0;
        check("t4_second_taken", s1.sample_ready, 0);
        h = int'(pwm1);
        repeat (255) begin
            @(negedge clk);
            h += int'(pwm1);
        end
        check("t4_first_duty", h, 138);
        period_high(h);
        check("t4_second_duty", h, 148);
        // 5: reset mid-period with a pending sample
        push(8'd100);
        repeat (5) @(negedge clk);
        check("t5_pwm_before", pwm1, 1);
        rst1 = 1'b1;
        @(negedge clk);
        check("t5_pwm", pwm1, 0);
        check("t5_ready", s1.sample_ready, 1);
        check("t5_req", req1, 0);
        rst1 = 1'b0;
        wait_req(n);
        check("t5_restart", n, 256);
        check("t5_pending_dropped", und1, 1);
        period_high(h);
        check("t5_mid_duty", h, 128);
        // 6: DIV=4 period and duty scaling
        rst4 = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req4 && n < 5000);
        check("t6_req_spacing", n, 1024);
        s4.sample_in = 8'd64;
        s4.sample_valid = 1'b1;
        @(negedge clk);
        s4.sample_valid = 1'b0;
        n = 1;
        do begin
            @(negedge clk);
            n++;
        end while (!req4 && n < 5000);
        check("t6_req_spacing2", n, 1024);
        h = 0;
        repeat (1024) begin
            @(negedge clk);
            h += int'(pwm4);
        end
        check("t6_high", h, 768);
        check("t6_underrun", und4, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pwm_audio_dac.md
Name: pwm_audio_dac

Overview:
Downstream audio output stage for the synth's signed 8-bit waveform generators (sine and similar oscillators). It accepts signed samples over a valid/ready handshake and converts them to offset-binary. It then drives a single-bit PWM pin, one sample per PWM period. It raises a per-period sample request and a sticky underrun flag when the source fails to deliver a sample in time.

Parameters:
WIDTH, 8, sample width in bits; the PWM counter is also WIDTH bits, so a period is 2^WIDTH ticks.
DIV, 1, clock prescaler (>=1); the PWM counter advances once every DIV clocks.

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
sample_in  in  WIDTH  signed two's-complement sample
sample_valid  in  1  sample_in is valid this cycle
sample_ready  out  1  block can accept a sample this cycle
sample_req  out  1  one-cycle pulse at every PWM period boundary
underrun  out  1  sticky: a period boundary found no pending sample
underrun_clr  in  1  clears underrun
pwm_out  out  1  registered PWM output

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset state: prescale=0, cnt=0, duty=2^(WIDTH-1) (mid-scale, silence), pending_valid=0, pwm_out=0, sample_req=0, underrun=0. sample_ready=1 from the first cycle after reset.
- Reset mid-operation: any pending sample is discarded and the period restarts from cnt=0.
- Offset-binary conversion: u = sample_in with MSB inverted. For WIDTH=8: -128->0, 0->128, 127->255. No other arithmetic.
- Tick:
  - tick = (prescale == DIV-1).
  - prescale wraps to 0 on tick, otherwise increments.
  - cnt increments on tick and wraps naturally modulo 2^WIDTH.
- Boundary: the cycle where tick && cnt == 2^WIDTH-1. On that edge cnt->0.
- Input buffer: one-entry register pending/pending_valid.
  - sample_ready = !pending_valid (combinational).
  - Accept when sample_valid && sample_ready; store u and set pending_valid.
- On a boundary edge:
  - If pending_valid: duty<=pending and pending_valid<=0.
  - Else: duty is held and underrun<=1.
  - sample_req is registered high for exactly the cycle following the boundary edge, regardless of load.
- Simultaneous events:
  - Boundary with pending empty plus an accept in the same cycle: the sample goes into pending, not duty; underrun is still set and the sample is used at the next boundary.
  - Boundary with pending full: ready=0, so no accept that cycle. Ready rises the cycle after.
  - underrun set and underrun_clr in the same cycle: set wins.
- PWM output: pwm_out <= (cnt < duty), using pre-edge values, so output lags the counter by one clock.
  - duty=0: output constantly low.
  - duty=2^WIDTH-1: high for 2^WIDTH-1 of 2^WIDTH ticks (never 100%).
  - High time per period = duty*DIV clocks.
- duty changes only at boundaries, so there are no glitches mid-period.

Decomposition:
- Shared synth package holds:
  - the default sample width constant (8)
  - the mid-scale constant 2^(WIDTH-1)
  - a to_offset_binary function (MSB invert), reused by future DAC / sigma-delta stages.
- Natural sub-module: pwm_tick_counter. It contains the prescaler and the WIDTH-bit counter, and outputs cnt, tick and boundary.
- The top level holds the input buffer, duty register, comparator and flags.

Test Plan:
1. Reset with no input, WIDTH=8, DIV=1:
   - pwm_out high 128 of every 256 clocks.
   - sample_ready=1; sample_req pulses every 256 clocks.
   - underrun=1 after the first boundary.
2. Push -128 before a boundary -> next period pwm_out low for all 256 clocks. Push 127 -> high 255 of 256. Push 0 -> high 128.
3. Feed one sample per sample_req for 10 periods -> underrun stays 0. Then withhold one sample -> underrun=1 and duty held at the previous value. Pulse underrun_clr -> underrun=0.
4. Back-to-back valid samples 10 and 20 -> 10 accepted, sample_ready=0 until the boundary. 20 is accepted the cycle after the boundary and loaded one period later.
5. Assert rst mid-period with a pending sample -> next cycle pwm_out=0, pending dropped, duty=128, cnt restarts at 0.
6. DIV=4 -> sample_req spacing 1024 clocks; sample 64 (u=192) gives 768 high clocks per period.
